// File: rtl/interrupt_ack_sequencer_8259a.sv
// interrupt_ack_sequencer_8259a
// Control stage behind the 8259A request register. It resolves the
// highest-priority eligible request in fully nested mode, raises INT, runs the
// two-pulse INTA handshake (freeze, clear pulse, ISR set, vector drive) and
// handles specific, non-specific and automatic end-of-interrupt.
module interrupt_ack_sequencer_8259a #(
    parameter int VECTOR_BASE_W = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [7:0]                 interrupt_request_register,
    input  logic [7:0]                 interrupt_mask,
    input  logic                       interrupt_acknowledge_n,
    input  logic                       end_of_interrupt,
    input  logic                       specific_eoi,
    input  logic [2:0]                 eoi_level,
    input  logic                       auto_eoi_config,
    input  logic [VECTOR_BASE_W-1:0]   vector_base,
    output logic                       interrupt_to_cpu,
    output logic                       freeze,
    output logic [7:0]                 clear_interrupt_request,
    output logic [7:0]                 in_service_register,
    output logic [VECTOR_BASE_W+2:0]   interrupt_vector,
    output logic                       vector_out_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       inta_prev_q, inta_prev_d;
    logic [2:0]                 acked_level_q, acked_level_d;
    logic                       spurious_q, spurious_d;
    logic                       int_q, int_d;
    logic                       freeze_q, freeze_d;
    logic [7:0]                 clear_q, clear_d;
    logic [7:0]                 isr_q, isr_d;
    logic [VECTOR_BASE_W+2:0]   vector_q, vector_d;
    logic                       voe_q, voe_d;

    logic                       inta_fall;
    logic                       inta_rise;
    logic [7:0]                 isr_lowest;
    logic [7:0]                 priority_window;
    logic [7:0]                 eligible;
    logic [2:0]                 winner;
    logic [7:0]                 eoi_clear_mask;
    logic [7:0]                 auto_clear_mask;
    logic [7:0]                 isr_set_mask;

    // INTA edges are judged against the previous sample of the pin.
    assign inta_fall = inta_prev_q & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n;
    assign inta_prev_d = interrupt_acknowledge_n;

    // Only levels strictly above the highest-priority in-service level may
    // interrupt; the lowest set ISR bit is that level, and everything below
    // its index is a higher priority.
    assign isr_lowest      = isr_q & (~isr_q + 8'd1);
    assign priority_window = (isr_q == 8'h00) ? 8'hFF : (isr_lowest - 8'd1);
    assign eligible        = interrupt_request_register & ~interrupt_mask & priority_window;

    // Fixed priority encoder: the lowest-numbered eligible level wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = i[2:0];
            end
        end
    end

    // EOI clears either the named level or the highest-priority set ISR bit.
    always_comb begin
        eoi_clear_mask = 8'h00;
        if (end_of_interrupt) begin
            if (specific_eoi) begin
                eoi_clear_mask = 8'd1 << eoi_level;
            end else begin
                eoi_clear_mask = isr_lowest;
            end
        end
    end

    // Handshake sequencing and next values of every registered output.
    always_comb begin
        state_d         = state_q;
        acked_level_d   = acked_level_q;
        spurious_d      = spurious_q;
        int_d           = 1'b0;
        freeze_d        = freeze_q;
        clear_d         = 8'h00;
        vector_d        = vector_q;
        voe_d           = voe_q;
        isr_set_mask    = 8'h00;
        auto_clear_mask = 8'h00;

        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d  = ACK1;
                    freeze_d = 1'b1;
                    if (eligible != 8'h00) begin
                        acked_level_d = winner;
                        spurious_d    = 1'b0;
                        clear_d       = 8'd1 << winner;
                        isr_set_mask  = 8'd1 << winner;
                    end else begin
                        acked_level_d = 3'd7;
                        spurious_d    = 1'b1;
                    end
                end else begin
                    int_d = (eligible != 8'h00);
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_d  = ACK2;
                    vector_d = {vector_base, acked_level_q};
                    voe_d    = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d  = IDLE;
                    voe_d    = 1'b0;
                    freeze_d = 1'b0;
                    if (auto_eoi_config && !spurious_q) begin
                        auto_clear_mask = 8'd1 << acked_level_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clears go first so a same-cycle set on the same bit wins.
        isr_d = (isr_q & ~eoi_clear_mask & ~auto_clear_mask) | isr_set_mask;
    end

    // All state and outputs are registered; reset aborts any handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            inta_prev_q   <= 1'b1;
            acked_level_q <= 3'd0;
            spurious_q    <= 1'b0;
            int_q         <= 1'b0;
            freeze_q      <= 1'b0;
            clear_q       <= 8'h00;
            isr_q         <= 8'h00;
            vector_q      <= '0;
            voe_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            inta_prev_q   <= inta_prev_d;
            acked_level_q <= acked_level_d;
            spurious_q    <= spurious_d;
            int_q         <= int_d;
            freeze_q      <= freeze_d;
            clear_q       <= clear_d;
            isr_q         <= isr_d;
            vector_q      <= vector_d;
            voe_q         <= voe_d;
        end
    end

    assign interrupt_to_cpu        = int_q;
    assign freeze                  = freeze_q;
    assign clear_interrupt_request = clear_q;
    assign in_service_register     = isr_q;
    assign interrupt_vector        = vector_q;
    assign vector_out_enable       = voe_q;

endmodule
